// File: rtl/image_pipe_arb.sv
// image_pipe_arb: frame-granular two-source arbiter feeding one image pipe.
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   srcN_data_in/valid_in/end_in   source N beat (N = 0, 1)
//   srcN_busy_out                  source N must hold its current beat
//   pipe_data/valid/end_out        registered beat towards the image pipe
//   pipe_busy_in                   backpressure from the image pipe
//   reg_cpu_*                      register bus (CTRL, STATUS, FCNT0, FCNT1)
//
// A source keeps its grant until it delivers an end beat, then the arbiter
// spends one cycle in IDLE choosing the next frame owner.
module image_pipe_arb #(
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] src0_data_in,
    input  logic          src0_valid_in,
    input  logic          src0_end_in,
    output logic          src0_busy_out,
    input  logic [DW-1:0] src1_data_in,
    input  logic          src1_valid_in,
    input  logic          src1_end_in,
    output logic          src1_busy_out,
    output logic [DW-1:0] pipe_data_out,
    output logic          pipe_valid_out,
    output logic          pipe_end_out,
    input  logic          pipe_busy_in,
    input  logic          reg_cpu_cs,
    input  logic [31:2]   reg_cpu_addr,
    input  logic [31:0]   reg_cpu_data_wr,
    output logic [31:0]   reg_cpu_data_rd,
    input  logic          reg_cpu_we,
    output logic          reg_cpu_wack,
    input  logic          reg_cpu_re,
    output logic          reg_cpu_rdv
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StGrant0 = 2'd1,
        StGrant1 = 2'd2
    } state_e;

    state_e      state_q;
    logic        last_grant_q;
    logic [2:0]  ctrl_q;        // bit0 en0, bit1 en1, bit2 fixed-priority mode
    logic [15:0] fcnt0_q;
    logic [15:0] fcnt1_q;
    logic        re_q;

    logic        acc0, acc1, end0, end1;
    logic        req0, req1, pick1;
    logic [13:0] reg_idx;
    logic        reg_wr, reg_rd_edge, wr_ctrl, clr_cnt;
    logic [31:0] rd_val;

    logic unused_bits;
    assign unused_bits = ^{reg_cpu_addr[31:16], reg_cpu_data_wr[31:3]};

    // Only the granted source may move, and only when the pipe is not stalled.
    assign src0_busy_out = (state_q != StGrant0) | pipe_busy_in;
    assign src1_busy_out = (state_q != StGrant1) | pipe_busy_in;

    assign acc0 = src0_valid_in & ~src0_busy_out;
    assign acc1 = src1_valid_in & ~src1_busy_out;
    assign end0 = acc0 & src0_end_in;
    assign end1 = acc1 & src1_end_in;

    // Enables only matter here, in IDLE; a running frame is never revoked.
    assign req0  = ctrl_q[0] & src0_valid_in;
    assign req1  = ctrl_q[1] & src1_valid_in;
    // Source 1 wins if alone, or on a round-robin tie when source 0 went last.
    assign pick1 = req1 & (~req0 | (~ctrl_q[2] & ~last_grant_q));

    assign reg_idx     = reg_cpu_addr[15:2];
    assign reg_wr      = reg_cpu_cs & reg_cpu_we;
    assign reg_rd_edge = reg_cpu_cs & reg_cpu_re & ~re_q;
    assign wr_ctrl     = reg_wr & (reg_idx == 14'h0);
    assign clr_cnt     = reg_wr & ((reg_idx == 14'h2) | (reg_idx == 14'h3));

    always_comb begin
        rd_val = 32'h0;
        case (reg_idx)
            14'h0:   rd_val = {29'h0, ctrl_q};
            14'h1:   rd_val = {29'h0, last_grant_q, state_q};
            14'h2:   rd_val = {16'h0, fcnt0_q};
            14'h3:   rd_val = {16'h0, fcnt1_q};
            default: rd_val = 32'h0;
        endcase
    end

    // Arbitration FSM with registered pipe outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            last_grant_q   <= 1'b1;
            pipe_data_out  <= '0;
            pipe_valid_out <= 1'b0;
            pipe_end_out   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req0 | req1) begin
                        state_q <= pick1 ? StGrant1 : StGrant0;
                    end
                end
                StGrant0: begin
                    if (end0) begin
                        state_q      <= StIdle;
                        last_grant_q <= 1'b0;
                    end
                end
                StGrant1: begin
                    if (end1) begin
                        state_q      <= StIdle;
                        last_grant_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Stalled pipe: hold everything, nothing can be accepted anyway.
            if (!pipe_busy_in) begin
                if (acc0) begin
                    pipe_data_out  <= src0_data_in;
                    pipe_valid_out <= 1'b1;
                    pipe_end_out   <= src0_end_in;
                end else if (acc1) begin
                    pipe_data_out  <= src1_data_in;
                    pipe_valid_out <= 1'b1;
                    pipe_end_out   <= src1_end_in;
                end else begin
                    pipe_data_out  <= '0;
                    pipe_valid_out <= 1'b0;
                    pipe_end_out   <= 1'b0;
                end
            end
        end
    end

    // Register bus and frame counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q          <= 3'h0;
            fcnt0_q         <= 16'h0;
            fcnt1_q         <= 16'h0;
            re_q            <= 1'b0;
            reg_cpu_data_rd <= 32'h0;
            reg_cpu_wack    <= 1'b0;
            reg_cpu_rdv     <= 1'b0;
        end else begin
            re_q         <= reg_cpu_re;
            reg_cpu_wack <= reg_wr;
            reg_cpu_rdv  <= reg_cpu_cs & reg_cpu_re;
            if (reg_rd_edge) begin
                reg_cpu_data_rd <= rd_val;
            end
            if (wr_ctrl) begin
                ctrl_q <= reg_cpu_data_wr[2:0];
            end
            // A clear discards any same-cycle increment.
            if (clr_cnt) begin
                fcnt0_q <= 16'h0;
                fcnt1_q <= 16'h0;
            end else begin
                if (end0) fcnt0_q <= fcnt0_q + 16'd1;
                if (end1) fcnt1_q <= fcnt1_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_image_pipe_arb.sv
// Randomized scoreboard bench for image_pipe_arb.
module tb_image_pipe_arb;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] src0_data_in, src1_data_in, pipe_data_out;
    logic          src0_valid_in, src0_end_in, src0_busy_out;
    logic          src1_valid_in, src1_end_in, src1_busy_out;
    logic          pipe_valid_out, pipe_end_out, pipe_busy_in;
    logic          reg_cpu_cs, reg_cpu_we, reg_cpu_re, reg_cpu_wack, reg_cpu_rdv;
    logic [31:2]   reg_cpu_addr;
    logic [31:0]   reg_cpu_data_wr, reg_cpu_data_rd;

    always #5 clk = ~clk;

    image_pipe_arb #(.DW(DW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .src0_data_in   (src0_data_in),
        .src0_valid_in  (src0_valid_in),
        .src0_end_in    (src0_end_in),
        .src0_busy_out  (src0_busy_out),
        .src1_data_in   (src1_data_in),
        .src1_valid_in  (src1_valid_in),
        .src1_end_in    (src1_end_in),
        .src1_busy_out  (src1_busy_out),
        .pipe_data_out  (pipe_data_out),
        .pipe_valid_out (pipe_valid_out),
        .pipe_end_out   (pipe_end_out),
        .pipe_busy_in   (pipe_busy_in),
        .reg_cpu_cs     (reg_cpu_cs),
        .reg_cpu_addr   (reg_cpu_addr),
        .reg_cpu_data_wr(reg_cpu_data_wr),
        .reg_cpu_data_rd(reg_cpu_data_rd),
        .reg_cpu_we     (reg_cpu_we),
        .reg_cpu_wack   (reg_cpu_wack),
        .reg_cpu_re     (reg_cpu_re),
        .reg_cpu_rdv    (reg_cpu_rdv)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          e;
        int            cyc;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] rd_q[$];
    int          nvec = 0;
    int          nmis = 0;

    // Reference model state
    int          cyc = 0;
    int          owner = -1;   // -1 idle, else granted source
    int          last = 1;
    logic [2:0]  m_ctrl = 3'h0;
    int          m_fcnt [2];
    logic        m_re_prev = 1'b0;
    bit          acc [2];
    bit          edge_busy = 1'b0;
    bit          edge_rst = 1'b1;
    bit          exp_wack = 1'b0;
    bit          exp_rdv = 1'b0;

    // Source generators
    logic [DW-1:0] s_data [2];
    bit            s_valid [2];
    bit            s_end [2];
    int            s_left [2];
    bit            gen_en [2];
    int            hole_pct = 0;
    int            busy_pct = 0;
    int            flen = 3;

    assign src0_data_in  = s_data[0];
    assign src0_valid_in = s_valid[0];
    assign src0_end_in   = s_end[0];
    assign src1_data_in  = s_data[1];
    assign src1_valid_in = s_valid[1];
    assign src1_end_in   = s_end[1];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] reg_value(input logic [13:0] idx);
        case (idx)
            14'h0:   return {29'h0, m_ctrl};
            14'h1:   return {29'h0, last[0], 2'(owner + 1)};
            14'h2:   return 32'(m_fcnt[0]);
            14'h3:   return 32'(m_fcnt[1]);
            default: return 32'h0;
        endcase
    endfunction

    // Reference model: evaluates each clock edge from the pre-edge inputs.
    initial begin
        bit            v [2];
        bit            e [2];
        logic [DW-1:0] d [2];
        int            cand[$];
        m_fcnt = '{0, 0};
        forever begin
            @(posedge clk);
            cyc++;
            edge_busy = pipe_busy_in;
            edge_rst  = !rst_n;
            acc = '{0, 0};
            v = '{src0_valid_in, src1_valid_in};
            e = '{src0_end_in, src1_end_in};
            d = '{src0_data_in, src1_data_in};
            if (!rst_n) begin
                owner = -1; last = 1; m_ctrl = 3'h0; m_fcnt = '{0, 0};
                m_re_prev = 1'b0; exp_wack = 1'b0; exp_rdv = 1'b0;
                exp_q.delete(); rd_q.delete();
            end else begin
                if (reg_cpu_cs && reg_cpu_re && !m_re_prev)
                    rd_q.push_back(reg_value(reg_cpu_addr[15:2]));
                exp_rdv   = reg_cpu_cs && reg_cpu_re;
                exp_wack  = reg_cpu_cs && reg_cpu_we;
                m_re_prev = reg_cpu_re;
                if (owner == -1) begin
                    cand.delete();
                    for (int s = 0; s < 2; s++)
                        if (m_ctrl[s] && v[s]) cand.push_back(s);
                    if (cand.size() == 1) owner = cand[0];
                    else if (cand.size() == 2) owner = m_ctrl[2] ? 0 : 1 - last;
                end else if (v[owner] && !pipe_busy_in) begin
                    acc[owner] = 1'b1;
                    exp_q.push_back('{d: d[owner], e: e[owner], cyc: cyc});
                    if (e[owner]) begin
                        m_fcnt[owner] = (m_fcnt[owner] + 1) % 65536;
                        last  = owner;
                        owner = -1;
                    end
                end
                if (reg_cpu_cs && reg_cpu_we) begin
                    case (reg_cpu_addr[15:2])
                        14'h0: m_ctrl = reg_cpu_data_wr[2:0];
                        14'h2, 14'h3: m_fcnt = '{0, 0};
                        default: ;
                    endcase
                end
            end
        end
    end

    // Source and backpressure drivers.
    initial begin
        for (int s = 0; s < 2; s++) begin
            s_data[s] = '0; s_valid[s] = 0; s_end[s] = 0; s_left[s] = 0; gen_en[s] = 0;
        end
        pipe_busy_in = 1'b0;
        forever begin
            @(negedge clk);
            for (int s = 0; s < 2; s++) begin
                if (acc[s]) s_valid[s] = 0;
                if (!s_valid[s] && gen_en[s] && $urandom_range(99) >= 32'(hole_pct)) begin
                    if (s_left[s] == 0) s_left[s] = (flen != 0) ? flen : 32'($urandom_range(4, 1));
                    s_data[s]  = $urandom;
                    s_left[s]--;
                    s_end[s]   = (s_left[s] == 0);
                    s_valid[s] = 1;
                end
            end
            pipe_busy_in = ($urandom_range(99) < 32'(busy_pct));
        end
    end

    // Monitor: checks DUT outputs mid-cycle against the model's expectations.
    initial begin
        logic [DW+1:0] last_s = '0;
        beat_t         b;
        forever begin
            @(negedge clk);
            #2;
            if (cyc == 0) continue;
            chk("src0_busy", 64'(src0_busy_out), 64'((owner != 0) || pipe_busy_in));
            chk("src1_busy", 64'(src1_busy_out), 64'((owner != 1) || pipe_busy_in));
            chk("wack", 64'(reg_cpu_wack), 64'(exp_wack));
            chk("rdv", 64'(reg_cpu_rdv), 64'(exp_rdv));
            if (reg_cpu_rdv) begin
                if (rd_q.size() == 0) begin
                    nvec++; nmis++;
                    $display("FAIL rd_unexpected: got 0x%0h, expected no read data", reg_cpu_data_rd);
                end else chk("data_rd", 64'(reg_cpu_data_rd), 64'(rd_q.pop_front()));
            end
            if (edge_rst) begin
                chk("pipe_reset", 64'({pipe_valid_out, pipe_end_out, pipe_data_out}), 64'h0);
            end else if (edge_busy) begin
                chk("pipe_hold", 64'({pipe_valid_out, pipe_end_out, pipe_data_out}), 64'(last_s));
            end else if (pipe_valid_out) begin
                if (exp_q.size() == 0) begin
                    nvec++; nmis++;
                    $display("FAIL pipe_extra: got beat 0x%0h, expected none", pipe_data_out);
                end else begin
                    b = exp_q.pop_front();
                    chk("pipe_data", 64'(pipe_data_out), 64'(b.d));
                    chk("pipe_end", 64'(pipe_end_out), 64'(b.e));
                    chk("pipe_latency", 64'(cyc), 64'(b.cyc));
                end
            end else begin
                chk("pipe_idle", 64'({pipe_end_out, pipe_data_out}), 64'h0);
            end
            last_s = {pipe_valid_out, pipe_end_out, pipe_data_out};
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic reg_write(input logic [13:0] idx, input logic [31:0] val);
        reg_cpu_cs = 1; reg_cpu_we = 1; reg_cpu_addr = {16'h0, idx}; reg_cpu_data_wr = val;
        @(negedge clk);
        reg_cpu_cs = 0; reg_cpu_we = 0;
        @(negedge clk);
    endtask

    task automatic reg_read(input logic [13:0] idx);
        reg_cpu_cs = 1; reg_cpu_re = 1; reg_cpu_addr = {16'h0, idx};
        @(negedge clk);
        reg_cpu_cs = 0; reg_cpu_re = 0;
        @(negedge clk);
    endtask

    task automatic wait_owner(input int s);
        int n = 0;
        while (owner != s && n < 400) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (owner != s) begin
            nmis++;
            $display("FAIL wait_grant: got no grant to source %0d, expected one within 400 cycles", s);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 0; reg_cpu_cs = 0; reg_cpu_we = 0; reg_cpu_re = 0;
        reg_cpu_addr = '0; reg_cpu_data_wr = '0;
        run(3);
        rst_n = 1;
        @(negedge clk);
        // Reset register values
        for (int i = 0; i < 4; i++) reg_read(14'(i));
        reg_read(14'h9);

        // Round-robin, continuous 3-beat frames
        reg_write(14'h0, 32'h3);
        flen = 3; hole_pct = 0; busy_pct = 0;
        gen_en = '{1, 1};
        run(60);
        reg_read(14'h1); reg_read(14'h2); reg_read(14'h3);

        // Fixed priority: source 0 always wins
        reg_write(14'h2, 32'h0);
        reg_write(14'h0, 32'h7);
        run(60);
        reg_read(14'h2); reg_read(14'h3);

        // Random frames, holes and backpressure, interleaved register traffic
        reg_write(14'h0, 32'h3);
        flen = 0; hole_pct = 20; busy_pct = 30;
        for (int i = 0; i < 40; i++) begin
            run($urandom_range(10, 1));
            case ($urandom_range(5))
                0: reg_write(14'h3, 32'h0);
                1: reg_read(14'h9);
                default: reg_read(14'($urandom_range(3)));
            endcase
        end

        // Status read during a source-1 grant
        wait_owner(1);
        reg_read(14'h1);

        // Disable source 1 mid-frame; its frame still completes
        wait_owner(1);
        reg_write(14'h0, 32'h1);
        run(150);
        reg_read(14'h3); reg_read(14'h1);

        // Counter clear
        reg_write(14'h2, 32'hffff_ffff);
        reg_read(14'h2); reg_read(14'h3);

        // Reset mid-frame abandons it
        reg_write(14'h0, 32'h3);
        wait_owner(0);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        reg_read(14'h0); reg_read(14'h1);
        reg_write(14'h0, 32'h3);
        run(80);

        // Drain
        gen_en = '{0, 0}; busy_pct = 0;
        run(20);
        chk("drain_pending_beats", 64'(exp_q.size()), 64'h0);
        chk("drain_pending_reads", 64'(rd_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
